// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - command sequencer driving a 4-bit bidirectional shift register
// Accepts hold/shift/load commands and emits per-step S1/S0, DSR/DSL and D controls.
module shift_reg_ctrl (
   input  logic       CP,
   input  logic       CR,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_cnt,
   input  logic [3:0] cmd_data,
   output logic       S1,
   output logic       S0,
   output logic       DSR,
   output logic       DSL,
   output logic [3:0] D,
   output logic       busy,
   output logic       done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state, state_nx;
   logic [1:0] op_q, op_nx;
   logic [3:0] data_q, data_nx;
   logic [2:0] last_q, last_nx;
   logic [2:0] idx_q, idx_nx;
   logic [7:0] drv_nx;
   logic       busy_nx;
   logic       done_nx;

   // Drive vector is {S1, S0, DSR, DSL, D}; pattern bits wrap modulo 4.
   function automatic logic [7:0] step_drive(input logic [1:0] op,
                                             input logic [3:0] data,
                                             input logic [2:0] idx);
      logic bit_v;
      bit_v = data[idx[1:0]];
      case (op)
         2'b01:   step_drive = {2'b01, bit_v, 1'b0, 4'h0};
         2'b10:   step_drive = {2'b10, 1'b0, bit_v, 4'h0};
         2'b11:   step_drive = {2'b11, 2'b00, data};
         default: step_drive = 8'h00;
      endcase
   endfunction

   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_nx = state;
      op_nx    = op_q;
      data_nx  = data_q;
      last_nx  = last_q;
      idx_nx   = idx_q;
      drv_nx   = 8'h00;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nx = RUN;
               op_nx    = cmd_op;
               data_nx  = cmd_data;
               // Count 0 wraps to 7 here, which is the last index of an 8-step run.
               last_nx  = (cmd_op == 2'b11) ? 3'd0 : cmd_cnt - 3'd1;
               idx_nx   = 3'd0;
               drv_nx   = step_drive(cmd_op, cmd_data, 3'd0);
               busy_nx  = 1'b1;
            end
         end
         RUN: begin
            if (idx_q == last_q) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               idx_nx  = idx_q + 3'd1;
               drv_nx  = step_drive(op_q, data_q, idx_q + 3'd1);
               busy_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         state  <= IDLE;
         op_q   <= 2'b00;
         data_q <= 4'h0;
         last_q <= 3'd0;
         idx_q  <= 3'd0;
         S1     <= 1'b0;
         S0     <= 1'b0;
         DSR    <= 1'b0;
         DSL    <= 1'b0;
         D      <= 4'h0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         op_q   <= op_nx;
         data_q <= data_nx;
         last_q <= last_nx;
         idx_q  <= idx_nx;
         {S1, S0, DSR, DSL, D} <= drv_nx;
         busy   <= busy_nx;
         done   <= done_nx;
      end
   end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - scoreboard bench for shift_reg_ctrl with an attached register model
module tb_shift_reg_ctrl;

   logic       CP = 1'b0;
   logic       CR = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_cnt = 3'd0;
   logic [3:0] cmd_data = 4'h0;
   logic       S1, S0, DSR, DSL;
   logic [3:0] D;
   logic       busy, done;

   shift_reg_ctrl dut (
      .CP(CP), .CR(CR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
      .S1(S1), .S0(S0), .DSR(DSR), .DSL(DSL), .D(D),
      .busy(busy), .done(done)
   );

   always #5 CP = ~CP;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         busy_cnt = 0;
   int         done_cnt = 0;
   logic [7:0] exp_q[$];
   logic [3:0] q;
   logic       q_clr = 1'b1;
   wire  [7:0] drv = {S1, S0, DSR, DSL, D};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 74194-style register: 01 shifts DSR in at Q0, 10 shifts DSL in at Q3.
   always @(posedge CP) begin
      if (q_clr) q <= 4'h0;
      else case ({S1, S0})
         2'b01:   q <= {q[2:0], DSR};
         2'b10:   q <= {DSL, q[3:1]};
         2'b11:   q <= D;
         default: q <= q;
      endcase
   end

   always @(negedge CP) begin
      if (busy) begin
         busy_cnt++;
         check("ready_in_run", cmd_ready, 0);
         if (exp_q.size() == 0) check("sb_depth", exp_q.size(), 1);
         else check("step_drive", drv, exp_q.pop_front());
      end else begin
         check("idle_drive", drv, 0);
      end
      if (done) done_cnt++;
   end

   task automatic push_cmd(input logic [1:0] op, input logic [2:0] cnt,
                           input logic [3:0] data, output int n);
      n = (op == 2'b11) ? 1 : (cnt == 3'd0) ? 8 : int'(cnt);
      for (int i = 0; i < n; i++) begin
         logic b;
         b = data[i % 4];
         case (op)
            2'b00: exp_q.push_back(8'h00);
            2'b01: exp_q.push_back({2'b01, b, 1'b0, 4'h0});
            2'b10: exp_q.push_back({2'b10, 1'b0, b, 4'h0});
            default: exp_q.push_back({4'b1100, data});
         endcase
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] cnt,
                        input logic [3:0] data, output int n);
      push_cmd(op, cnt, data, n);
      busy_cnt = 0;
      done_cnt = 0;
      check("ready_before", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = data;
   endtask

   task automatic accept_and_drop();
      @(posedge CP); #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_cnt   = 3'($urandom);
      cmd_data  = 4'($urandom);
   endtask

   task automatic wait_done(input string tag, input int n, input logic [3:0] q_exp);
      int k;
      k = 0;
      while (!done && k < 40) begin
         @(negedge CP);
         k++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_cycles"}, busy_cnt, n);
      check({tag, "_ready"}, cmd_ready, 1);
      check({tag, "_idle_drive"}, drv, 0);
      check({tag, "_q"}, q, q_exp);
      check({tag, "_sb_left"}, exp_q.size(), 0);
      @(negedge CP);
      check({tag, "_done_drop"}, done, 0);
      check({tag, "_done_pulses"}, done_cnt, 1);
      @(posedge CP); #1;
   endtask

   initial begin
      int n;
      int k;

      repeat (2) @(negedge CP);
      check("rst_drive", drv, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cmd_ready, 1);
      @(posedge CP); #1;
      CR    = 1'b1;
      q_clr = 1'b0;

      issue(2'b11, 3'd0, 4'b1010, n);
      accept_and_drop();
      wait_done("load", n, 4'b1010);

      q_clr = 1'b1; @(posedge CP); #1; q_clr = 1'b0;
      issue(2'b01, 3'd4, 4'b0110, n);
      accept_and_drop();
      wait_done("shift_dsr", n, 4'b0110);

      q_clr = 1'b1; @(posedge CP); #1; q_clr = 1'b0;
      issue(2'b10, 3'd4, 4'b0011, n);
      accept_and_drop();
      wait_done("shift_dsl", n, 4'b0011);

      // Eight-step run with stray valid pulses that must be ignored.
      issue(2'b01, 3'd0, 4'b1001, n);
      @(posedge CP); #1;
      cmd_op   = 2'b11;
      cmd_data = 4'hf;
      for (int p = 0; p < 3; p++) begin
         cmd_valid = 1'b1; @(posedge CP); #1;
         cmd_valid = 1'b0; @(posedge CP); #1;
      end
      wait_done("wrap", n, 4'b1001);

      // Hold for 3 steps with a load already pending; load must land at E4.
      issue(2'b00, 3'd3, 4'b1111, n);
      @(posedge CP); #1;
      cmd_op   = 2'b11;
      cmd_cnt  = 3'd5;
      cmd_data = 4'b0101;
      push_cmd(2'b11, 3'd5, 4'b0101, k);
      k = 0;
      while (!done && k < 40) begin
         @(negedge CP);
         k++;
      end
      check("hold_done", done, 1);
      check("hold_busy_cycles", busy_cnt, n);
      check("hold_q", q, 4'b1001);
      check("hold_ready", cmd_ready, 1);
      @(posedge CP); #1;
      check("b2b_accept", busy, 1);
      cmd_valid = 1'b0;
      check("hold_done_pulses", done_cnt, 1);
      busy_cnt = 0;
      done_cnt = 0;
      wait_done("b2b_load", 1, 4'b0101);

      // Reset between E2 and E3 of a 4-step shift.
      issue(2'b01, 3'd4, 4'b0110, n);
      accept_and_drop();
      @(posedge CP); #1;
      @(posedge CP); #3;
      CR = 1'b0;
      #1;
      check("mid_rst_drive", drv, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", cmd_ready, 1);
      exp_q.delete();
      @(posedge CP); #3;
      CR = 1'b1;
      @(posedge CP); #1;
      check("mid_rst_no_done", done_cnt, 0);
      issue(2'b11, 3'd0, 4'b1100, n);
      accept_and_drop();
      wait_done("post_rst_load", n, 4'b1100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
